packet_fifo: RTL and testbench
==============================

PACKET_FIFO -- requirements
Module: packet_fifo

Interface
REQ-001 Parameter DEPTH, default 64, byte capacity of storage; power of two, minimum 8.
REQ-002 clk  input  1  single clock; all state sampled on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 packet_in  axis_interface.Sink  DATA_WIDTH 8  COBS byte stream from xadc_packetizer; each packet is terminated by byte 0x00.
REQ-005 packet_out  axis_interface.Source  DATA_WIDTH 8  byte stream toward the USB transmit path; only complete packets are presented.
REQ-006 dropped_packets  output  16  count of discarded packets; present only when PACKET_FIFO_DROP_COUNT_EN is defined.

Function
REQ-007 Transfers occur when tvalid and tready are both high at a rising clk edge; this applies to both streams.
REQ-008 packet_in.tready is high whenever rst is low; the block never back-pressures the packetizer.
REQ-009 Storage is a DEPTH x 8 circular buffer; wr_ptr, wr_commit and rd_ptr are log2(DEPTH)+1 bits, and wrap modulo 2*DEPTH; used = wr_ptr - rd_ptr.
REQ-010 FSM states are ACCEPT and DISCARD; reset state is ACCEPT.
REQ-011 ACCEPT, byte accepted, used < DEPTH: the byte is written at wr_ptr and wr_ptr is incremented.
REQ-012 ACCEPT, accepted byte == 0x00 with space available: the byte is stored, wr_commit <= wr_ptr+1, and packet_count is incremented.
REQ-013 ACCEPT, byte accepted, used == DEPTH: the byte is dropped, wr_ptr <= wr_commit (partial packet erased), dropped_packets increments, and the FSM goes to DISCARD; if that byte is 0x00, the FSM stays in ACCEPT.
REQ-014 DISCARD: every accepted byte is dropped; an accepted 0x00 returns the FSM to ACCEPT, with no storage and no count change.
REQ-015 packet_out.tvalid == (packet_count != 0), registered; packet_out.tdata is mem[rd_ptr], first-word fall-through.
REQ-016 On each output transfer, rd_ptr increments; if the transferred byte is 0x00, packet_count decrements.
REQ-017 A simultaneous packet_count increment and decrement leaves packet_count unchanged.
REQ-018 Free space is computed against rd_ptr in the same cycle; a byte read on the same edge does not free space for a write on that edge.
REQ-019 Latency: the terminating 0x00 is accepted at edge N; packet_out.tvalid is high after edge N+1 at the latest, and the first byte of that packet is presented.
REQ-020 A packet longer than DEPTH bytes, including its 0x00, is always dropped and never partially emitted.
REQ-021 Bytes of an uncommitted packet, between wr_commit and wr_ptr, are never visible on packet_out.
REQ-022 packet_count is log2(DEPTH)+1 bits wide and cannot overflow, since each packet occupies at least 1 byte.
REQ-023 dropped_packets saturates at 0xFFFF.

Reset
REQ-024 While rst is high: all pointers 0, packet_count 0, FSM ACCEPT, packet_in.tready 0, packet_out.tvalid 0, dropped_packets 0.
REQ-025 Reset asserted mid-packet discards all stored and partial data; after deassertion, the first input byte begins a new packet.
REQ-026 Memory contents are not reset.

Configuration
REQ-027 Macro PACKET_FIFO_DROP_COUNT_EN defined: the dropped_packets port and its 16-bit saturating counter exist, incremented per REQ-013.
REQ-028 Macro PACKET_FIFO_DROP_COUNT_EN undefined: the port and counter are absent; drop behaviour is otherwise identical.

Verification
REQ-029 Single packet: input 01 02 FF 02 7F 00 with packet_out.tready=1 -> output is exactly 01 02 FF 02 7F 00, and tvalid goes low after the last 00.
REQ-030 Hold packet: input 01 02 FF 02 7F 00 followed by 03 11 22 00 with tready=0 -> tvalid is high from 1 cycle after the first 00, and no byte of the second packet appears before the first packet drains.
REQ-031 Overflow: DEPTH=8, tready=0, input 6-byte packet then 05 AA BB CC DD 00 -> only the first packet is stored, dropped_packets=1, and the FSM returns to ACCEPT.
REQ-032 Oversize: DEPTH=8, empty buffer, 10-byte packet -> nothing is emitted and dropped_packets=1; a following 2-byte packet 01 00 is emitted intact.
REQ-033 Concurrent: continuous 3-byte packets 02 55 00 with tready toggling every cycle -> output matches input byte-for-byte, and packet_count never underflows.
REQ-034 Mid-packet reset: assert rst after 01 02 FF -> outputs go to reset values; after release, input 01 00 yields output 01 00 only.

Source files
------------

// File: rtl/packet_fifo.sv
// packet_fifo: store-and-forward byte FIFO that only releases complete 0x00-terminated packets
//              (define PACKET_FIFO_DROP_COUNT_EN to add the dropped_packets counter port)
module packet_fifo #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        packet_in_tvalid,
    input  logic [7:0]  packet_in_tdata,
    output logic        packet_in_tready,
    output logic        packet_out_tvalid,
    output logic [7:0]  packet_out_tdata,
    input  logic        packet_out_tready
`ifdef PACKET_FIFO_DROP_COUNT_EN
    ,
    output logic [15:0] dropped_packets
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {ACCEPT, DISCARD} state_t;

    state_t      state, state_n;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr, packet_count, used;
    logic        in_fire, out_fire, full, we, commit, release_pkt;

    assign packet_in_tready  = !rst;
    assign in_fire           = packet_in_tvalid && packet_in_tready;
    assign out_fire          = packet_out_tvalid && packet_out_tready;
    assign used              = wr_ptr - rd_ptr;
    assign full              = used == FULL_LEVEL;
    assign packet_out_tvalid = packet_count != '0;
    assign packet_out_tdata  = mem[rd_ptr[AW-1:0]];
    assign release_pkt       = out_fire && packet_out_tdata == 8'h00;

    // Next-state: store while there is room, rewind to the last commit point on overflow
    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        wr_commit_n = wr_commit;
        we          = 1'b0;
        commit      = 1'b0;
        if (in_fire) begin
            if (state == DISCARD) begin
                state_n = packet_in_tdata == 8'h00 ? ACCEPT : DISCARD;
            end else if (!full) begin
                we       = 1'b1;
                wr_ptr_n = wr_ptr + 1'b1;
                if (packet_in_tdata == 8'h00) begin
                    commit      = 1'b1;
                    wr_commit_n = wr_ptr + 1'b1;
                end
            end else begin
                wr_ptr_n = wr_commit;
                state_n  = packet_in_tdata == 8'h00 ? ACCEPT : DISCARD;
            end
        end
    end

    // State, pointers and the count of complete packets held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ACCEPT;
            wr_ptr       <= '0;
            wr_commit    <= '0;
            rd_ptr       <= '0;
            packet_count <= '0;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_ptr_n;
            wr_commit    <= wr_commit_n;
            rd_ptr       <= out_fire ? rd_ptr + 1'b1 : rd_ptr;
            packet_count <= (commit && !release_pkt) ? packet_count + 1'b1 :
                            (!commit && release_pkt) ? packet_count - 1'b1 : packet_count;
        end
    end

    // Byte storage; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr[AW-1:0]] <= packet_in_tdata;
    end

`ifdef PACKET_FIFO_DROP_COUNT_EN
    logic drop;
    assign drop = in_fire && state == ACCEPT && full;

    // Saturating count of packets lost to overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dropped_packets <= '0;
        else if (drop && dropped_packets != 16'hFFFF) dropped_packets <= dropped_packets + 1'b1;
    end
`endif
endmodule

// File: tb/tb_packet_fifo.sv
// tb_packet_fifo: directed checks of packet_fifo at DEPTH=8 and DEPTH=64
module tb_packet_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready8, out_valid8, in_ready64, out_valid64;
    logic [7:0] out_data8, out_data64;
`ifdef PACKET_FIFO_DROP_COUNT_EN
    logic [15:0] drop8, drop64;
`endif
    int total = 0;
    int bad = 0;
    logic [7:0] q8[$], q64[$], exp[$], pk[$];

    always #5 clk = ~clk;

    packet_fifo #(.DEPTH(8)) u8 (
        .clk(clk), .rst(rst),
        .packet_in_tvalid(in_valid), .packet_in_tdata(in_data), .packet_in_tready(in_ready8),
        .packet_out_tvalid(out_valid8), .packet_out_tdata(out_data8), .packet_out_tready(out_ready)
`ifdef PACKET_FIFO_DROP_COUNT_EN
        , .dropped_packets(drop8)
`endif
    );

    packet_fifo #(.DEPTH(64)) u64 (
        .clk(clk), .rst(rst),
        .packet_in_tvalid(in_valid), .packet_in_tdata(in_data), .packet_in_tready(in_ready64),
        .packet_out_tvalid(out_valid64), .packet_out_tdata(out_data64), .packet_out_tready(out_ready)
`ifdef PACKET_FIFO_DROP_COUNT_EN
        , .dropped_packets(drop64)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        if (!rst && out_valid8 && out_ready) q8.push_back(out_data8);
        if (!rst && out_valid64 && out_ready) q64.push_back(out_data64);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_pk();
        foreach (pk[i]) begin
            in_valid = 1'b1;
            in_data = pk[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic cmp(input bit big, input string tag);
        logic [7:0] q[$];
        if (big) q = q64;
        else q = q8;
        chk({tag, "_len"}, q.size(), exp.size());
        for (int i = 0; i < q.size() && i < exp.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), q[i], exp[i]);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        in_valid = 1'b0;
        idle(2);
        chk({tag, "_rst_in_ready8"}, in_ready8, 0);
        chk({tag, "_rst_out_valid8"}, out_valid8, 0);
        chk({tag, "_rst_out_valid64"}, out_valid64, 0);
`ifdef PACKET_FIFO_DROP_COUNT_EN
        chk({tag, "_rst_drop8"}, drop8, 0);
`endif
        rst = 1'b0;
        #1;
        chk({tag, "_in_ready8"}, in_ready8, 1);
        q8.delete();
        q64.delete();
    endtask

    initial begin
        do_reset("t1");
        out_ready = 1'b1;
        pk = '{8'h01, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00};
        send_pk();
        idle(10);
        exp = pk;
        cmp(0, "t1_single8");
        cmp(1, "t1_single64");
        chk("t1_valid_low", out_valid8, 0);

        do_reset("t2");
        out_ready = 1'b0;
        send_pk();
        in_valid = 1'b1;
        in_data = 8'h03;
        tick();
        chk("t2_valid_after_eop", out_valid64, 1);
        chk("t2_first_byte", out_data64, 8'h01);
        pk = '{8'h11, 8'h22, 8'h00};
        send_pk();
        chk("t2_hold_valid", out_valid64, 1);
        chk("t2_hold_byte", out_data64, 8'h01);
        out_ready = 1'b1;
        idle(20);
        exp = '{8'h01, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00, 8'h03, 8'h11, 8'h22, 8'h00};
        cmp(1, "t2_hold64");
        exp = '{8'h01, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00};
        cmp(0, "t2_hold8");
`ifdef PACKET_FIFO_DROP_COUNT_EN
        chk("t2_drop8", drop8, 1);
        chk("t2_drop64", drop64, 0);
`endif

        do_reset("t3");
        out_ready = 1'b0;
        pk = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00};
        send_pk();
        pk = '{8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_pk();
        pk = '{8'h01, 8'h00};
        send_pk();
        out_ready = 1'b1;
        idle(20);
        exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00, 8'h01, 8'h00};
        cmp(0, "t3_overflow");
`ifdef PACKET_FIFO_DROP_COUNT_EN
        chk("t3_drop8", drop8, 1);
`endif

        do_reset("t4");
        out_ready = 1'b1;
        pk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h00};
        send_pk();
        idle(4);
        chk("t4_nothing_out", q8.size(), 0);
        pk = '{8'h01, 8'h00};
        send_pk();
        idle(8);
        exp = '{8'h01, 8'h00};
        cmp(0, "t4_oversize");
`ifdef PACKET_FIFO_DROP_COUNT_EN
        chk("t4_drop8", drop8, 1);
`endif

        do_reset("t5");
        out_ready = 1'b0;
        pk = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h00};
        send_pk();
        chk("t5_exact_fit_valid", out_valid8, 1);
        pk = '{8'h00};
        send_pk();
        out_ready = 1'b1;
        idle(12);
        pk = '{8'h01, 8'h00};
        send_pk();
        idle(6);
        exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'h00, 8'h01, 8'h00};
        cmp(0, "t5_full_eop");
`ifdef PACKET_FIFO_DROP_COUNT_EN
        chk("t5_drop8", drop8, 1);
`endif

        do_reset("t6");
        out_ready = 1'b0;
        exp.delete();
        pk = '{8'h02, 8'h55, 8'h00};
        for (int p = 0; p < 8; p++) begin
            foreach (pk[i]) begin
                out_ready = ~out_ready;
                in_valid = 1'b1;
                in_data = pk[i];
                exp.push_back(pk[i]);
                tick();
            end
        end
        in_valid = 1'b0;
        repeat (60) begin
            out_ready = ~out_ready;
            tick();
        end
        cmp(1, "t6_concurrent64");
        chk("t6_valid64_low", out_valid64, 0);
        chk("t6_valid8_low", out_valid8, 0);
        chk("t6_whole_pkts8", q8.size() % 3, 0);
        for (int i = 0; i < q8.size(); i++)
            chk($sformatf("t6_pkt8_b%0d", i), q8[i], exp[i]);

        do_reset("t7");
        out_ready = 1'b0;
        pk = '{8'h07, 8'h00, 8'h01, 8'h02, 8'hFF};
        send_pk();
        chk("t7_valid_before", out_valid8, 1);
        rst = 1'b1;
        #1;
        chk("t7_async_valid8", out_valid8, 0);
        chk("t7_async_valid64", out_valid64, 0);
        chk("t7_async_in_ready8", in_ready8, 0);
        idle(2);
        rst = 1'b0;
        #1;
        q8.delete();
        q64.delete();
        out_ready = 1'b1;
        pk = '{8'h01, 8'h00};
        send_pk();
        idle(6);
        exp = '{8'h01, 8'h00};
        cmp(0, "t7_after_rst8");
        cmp(1, "t7_after_rst64");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
